// File: rtl/pwm_reg_ctrl.sv
// Register-bank controller: validates decoded SPI frames, writes live output enables and
// double-buffers PWM enables/duty so they only change on a period boundary or a flush timeout.
module pwm_reg_ctrl #(
  parameter int NUM_REGS      = 5,
  parameter int ADDR_W        = 7,
  parameter int DATA_W        = 8,
  parameter int FLUSH_TIMEOUT = 4096
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                frame_valid,
  output logic                frame_ready,
  input  logic                frame_rw,
  input  logic [ADDR_W-1:0]   frame_addr,
  input  logic [DATA_W-1:0]   frame_data,
  input  logic                pwm_period_end,
  output logic [2*DATA_W-1:0] en_out,
  output logic [2*DATA_W-1:0] en_pwm,
  output logic [DATA_W-1:0]   duty,
  output logic                pending,
  output logic                wr_ack,
  output logic                wr_err,
  output logic [7:0]          err_cnt
);

  localparam int CNT_W = (FLUSH_TIMEOUT > 1) ? $clog2(FLUSH_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(FLUSH_TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] ADDR_LIM  = ADDR_W'(NUM_REGS);
  localparam logic [ADDR_W-1:0] A_OUT_LO  = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_OUT_HI  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_PWM_LO  = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_PWM_HI  = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] A_DUTY    = ADDR_W'(4);

  typedef enum logic {S_IDLE, S_CHECK} state_t;

  state_t             state, state_nxt;
  logic               take, act;
  logic               cap_rw;
  logic [ADDR_W-1:0]  cap_addr;
  logic [DATA_W-1:0]  cap_data;
  logic [DATA_W-1:0]  shadow_pwm_lo, shadow_pwm_hi, shadow_duty;
  logic [CNT_W-1:0]   tmo_cnt;
  logic               bad, wr_ok, rej, shadow_wr, commit;

  // Ready is gated by rst so the decoder sees "not ready" for the whole reset window.
  assign frame_ready = (state == S_IDLE) && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    act       = 1'b0;
    case (state)
      S_IDLE: begin
        if (frame_valid && frame_ready) begin
          take      = 1'b1;
          state_nxt = S_CHECK;
        end
      end
      S_CHECK: begin
        act       = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign bad       = !cap_rw || (cap_addr >= ADDR_LIM);
  assign wr_ok     = act && !bad;
  assign rej       = act && bad;
  assign shadow_wr = wr_ok && ((cap_addr == A_PWM_LO) || (cap_addr == A_PWM_HI) ||
                               (cap_addr == A_DUTY));
  assign commit    = pending && (pwm_period_end || (tmo_cnt == CNT_LAST));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_rw   <= 1'b0;
      cap_addr <= '0;
      cap_data <= '0;
    end else if (take) begin
      cap_rw   <= frame_rw;
      cap_addr <= frame_addr;
      cap_data <= frame_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_out        <= '0;
      shadow_pwm_lo <= '0;
      shadow_pwm_hi <= '0;
      shadow_duty   <= '0;
    end else if (wr_ok) begin
      if (cap_addr == A_OUT_LO) en_out[DATA_W-1:0]        <= cap_data;
      if (cap_addr == A_OUT_HI) en_out[2*DATA_W-1:DATA_W] <= cap_data;
      if (cap_addr == A_PWM_LO) shadow_pwm_lo             <= cap_data;
      if (cap_addr == A_PWM_HI) shadow_pwm_hi             <= cap_data;
      if (cap_addr == A_DUTY)   shadow_duty               <= cap_data;
    end
  end

  // Commit reads the pre-edge shadows, so a shadow write on the commit edge stays pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_pwm  <= '0;
      duty    <= '0;
      pending <= 1'b0;
      tmo_cnt <= '0;
    end else begin
      if (commit) begin
        en_pwm <= {shadow_pwm_hi, shadow_pwm_lo};
        duty   <= shadow_duty;
      end
      if (shadow_wr)   pending <= 1'b1;
      else if (commit) pending <= 1'b0;
      if (commit || !pending) tmo_cnt <= '0;
      else                    tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ack  <= 1'b0;
      wr_err  <= 1'b0;
      err_cnt <= '0;
    end else begin
      wr_ack <= wr_ok;
      wr_err <= rej;
      if (rej && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
    end
  end

endmodule
